// File: rtl/fragment_stream_receiver.sv
// fragment_stream_receiver
// Receives interpolated fragments from a non-stallable source, converts the
// s/t texture coordinates from IEEE-754 single to Q16.16 in a one-cycle
// conversion stage, and buffers the result in a first-word-fall-through FIFO.
// Because the source cannot be stopped, the block raises stall_req early
// enough to leave room for beats already in the interpolator pipeline. When
// the FIFO is still full, beats are dropped and a sticky overflow flag is set.
// Optional feature: define FRAGMENT_RECEIVER_DROP_COUNT_EN to add a 16-bit
// saturating drop_count output.
module fragment_stream_receiver #(
    parameter int FIFO_DEPTH    = 64,
    parameter int STALL_RESERVE = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic         s_axis_tlast,
    input  logic [159:0] s_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tlast,
    output logic [159:0] m_axis_tdata,
    output logic         stall_req,
    output logic         busy,
`ifdef FRAGMENT_RECEIVER_DROP_COUNT_EN
    output logic         overflow,
    output logic [15:0]  drop_count
`else
    output logic         overflow
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LEVEL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - STALL_RESERVE);

    // Float to Q16.16. The 24-bit significand has its binary point at bit 23,
    // so a Q16.16 result is the significand shifted by (e + 16 - 23) = exp - 134.
    // Exponents below 111 (e < -16) underflow to zero; at or above 142
    // (e >= 15) the integer part no longer fits in 15 bits and we saturate.
    function automatic logic [31:0] float_to_q16(input logic [31:0] f);
        logic [7:0]  exp;
        logic [31:0] mag;
        exp = f[30:23];
        mag = {8'd0, 1'b1, f[22:0]};
        if (exp == 8'd0 || exp < 8'd111) begin
            float_to_q16 = 32'd0;
        end else if (exp >= 8'd142) begin
            float_to_q16 = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            if (exp >= 8'd134) begin
                mag = mag << (exp - 8'd134);
            end else begin
                mag = mag >> (8'd134 - exp);
            end
            // Negating the truncated magnitude truncates toward zero.
            float_to_q16 = f[31] ? (32'd0 - mag) : mag;
        end
    endfunction

    logic [31:0]  w_conv [2];
    logic         r_c_valid;
    logic         r_c_last;
    logic [159:0] r_c_data;

    logic [160:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic         r_stall;
    logic         r_overflow;

    logic         w_empty;
    logic         w_full;
    logic         w_rd_en;
    logic         w_wr_en;
    logic         w_drop;
    logic [160:0] w_rd_word;

    // One converter per texture coordinate word (s is word 0, t is word 1).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_conv
            assign w_conv[gi] = float_to_q16(s_axis_tdata[gi*32 +: 32]);
        end
    endgenerate

    // Conversion stage: valid is reset, payload only loads on a valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_valid <= 1'b0;
        end else begin
            r_c_valid <= s_axis_tvalid;
        end
        if (s_axis_tvalid) begin
            r_c_data <= {s_axis_tdata[159:64], w_conv[1], w_conv[0]};
            r_c_last <= s_axis_tlast;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_LEVEL);
    assign w_rd_en = !w_empty && m_axis_tready;
    // A full FIFO still takes the beat when a read frees a slot this cycle.
    assign w_wr_en = r_c_valid && (!w_full || w_rd_en);
    assign w_drop  = r_c_valid && w_full && !w_rd_en;

    // Buffer storage; tlast is kept alongside its fragment.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {r_c_last, r_c_data};
        end
    end

    assign w_rd_word = r_mem[r_rd_ptr];

    // Pointers, fill count, stall request and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_stall <= (r_count >= STALL_LEVEL);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef FRAGMENT_RECEIVER_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    // Saturating count of dropped beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign s_axis_tready = 1'b1;
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_rd_word[159:0];
    assign m_axis_tlast  = w_rd_word[160];
    assign stall_req     = r_stall;
    assign busy          = r_c_valid || !w_empty;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_fragment_stream_receiver.sv
// Directed testbench for fragment_stream_receiver (default parameters).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_fragment_stream_receiver;

    logic         clk = 1'b0;
    logic         reset;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [159:0] s_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [159:0] m_axis_tdata;
    logic         stall_req;
    logic         busy;
    logic         overflow;
`ifdef FRAGMENT_RECEIVER_DROP_COUNT_EN
    logic [15:0]  drop_count;
`endif

    int tests = 0;
    int fails = 0;

    logic [31:0] cv_in  [12];
    logic [31:0] cv_exp [12];

    always #5 clk = ~clk;

    fragment_stream_receiver #(.FIFO_DEPTH(64), .STALL_RESERVE(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .stall_req     (stall_req),
        .busy          (busy),
`ifdef FRAGMENT_RECEIVER_DROP_COUNT_EN
        .overflow      (overflow),
        .drop_count    (drop_count)
`else
        .overflow      (overflow)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] s, input logic [31:0] t,
                         input logic [31:0] w, input logic [31:0] c,
                         input logic [31:0] fb, input logic last);
        s_axis_tvalid = v;
        s_axis_tdata  = {fb, c, w, t, s};
        s_axis_tlast  = last;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'h3F800000, 32'h3F800000, 0, 0, 0, 1'b0);
        m_axis_tready = 1'b0;
        tick(); tick();
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: tvalid=%b busy=%b stall=%b ovf=%b required 0000",
                     m_axis_tvalid, busy, stall_req, overflow);
        end
        tests++;
        if (s_axis_tready !== 1'b1) begin
            fails++;
            $display("FAIL tready_tied: got %b required 1", s_axis_tready);
        end
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        reset = 1'b0;
        tick(); tick();
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: tvalid=%b busy=%b required 00", m_axis_tvalid, busy);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_beat();
        m_axis_tready = 1'b1;
        drive(1'b1, 32'h3F800000, 32'hC0200000, 32'h3F000000, 32'h00AB, 32'h0055, 1'b1);
        tick();
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_n1: tvalid=%b busy=%b required tvalid=0 busy=1", m_axis_tvalid, busy);
        end
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 ||
            m_axis_tdata !== {32'h0055, 32'h00AB, 32'h3F000000, 32'hFFFD8000, 32'h00010000}) begin
            fails++;
            $display("FAIL single_n2: tvalid=%b last=%b data=%h required 1 1 %h", m_axis_tvalid,
                     m_axis_tlast, m_axis_tdata,
                     {32'h0055, 32'h00AB, 32'h3F000000, 32'hFFFD8000, 32'h00010000});
        end
        $display("[TB] single beat out s=%h t=%h w=%h", m_axis_tdata[31:0], m_axis_tdata[63:32],
                 m_axis_tdata[95:64]);
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_n3: tvalid=%b busy=%b required 00", m_axis_tvalid, busy);
        end
    endtask

    task automatic test_convert();
        int n;
        int idx;
        n = 12;
        cv_in[0]  = 32'h3F800000; cv_exp[0]  = 32'h00010000;  // 1.0
        cv_in[1]  = 32'hC0200000; cv_exp[1]  = 32'hFFFD8000;  // -2.5
        cv_in[2]  = 32'h47800000; cv_exp[2]  = 32'h7FFFFFFF;  // 65536.0 saturates
        cv_in[3]  = 32'hC7800000; cv_exp[3]  = 32'h80000000;  // -65536.0 saturates
        cv_in[4]  = 32'h37800000; cv_exp[4]  = 32'h00000001;  // 2^-16, e = -16: one LSB
        cv_in[5]  = 32'h37000000; cv_exp[5]  = 32'h00000000;  // 2^-17 underflows
        cv_in[6]  = 32'h00000000; cv_exp[6]  = 32'h00000000;  // +0
        cv_in[7]  = 32'h80000000; cv_exp[7]  = 32'h00000000;  // -0
        cv_in[8]  = 32'h46FFFFFE; cv_exp[8]  = 32'h7FFFFF00;  // e = 14, largest unsaturated
        cv_in[9]  = 32'hBF400000; cv_exp[9]  = 32'hFFFF4000;  // -0.75
        cv_in[10] = 32'h3F7FFFFF; cv_exp[10] = 32'h0000FFFF;  // just below 1, truncated
        cv_in[11] = 32'hBF7FFFFF; cv_exp[11] = 32'hFFFF0001;  // toward zero when negative
        m_axis_tready = 1'b1;
        for (int c = 0; c < n + 2; c++) begin
            if (c < n) begin
                drive(1'b1, cv_in[c], cv_in[(c + 5) % n], 32'h3F000000 + c, c, 32'h1000 + c, c == n - 1);
            end else begin
                drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
            end
            if (c >= 2) begin
                idx = c - 2;
                tests++;
                if (m_axis_tvalid !== 1'b1 ||
                    m_axis_tdata !== {32'h1000 + idx, 32'(idx), 32'h3F000000 + idx,
                                      cv_exp[(idx + 5) % n], cv_exp[idx]} ||
                    m_axis_tlast !== (idx == n - 1)) begin
                    fails++;
                    $display("FAIL convert_%0d: in=%h tvalid=%b last=%b data=%h required s=%h t=%h",
                             idx, cv_in[idx], m_axis_tvalid, m_axis_tlast, m_axis_tdata,
                             cv_exp[idx], cv_exp[(idx + 5) % n]);
                end
                $display("[TB] convert in=%h out=%h", cv_in[idx], m_axis_tdata[31:0]);
            end else begin
                tests++;
                if (m_axis_tvalid !== 1'b0) begin
                    fails++;
                    $display("FAIL convert_latency_%0d: tvalid=%b required 0", c, m_axis_tvalid);
                end
            end
            tick();
        end
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL convert_drained: tvalid=%b busy=%b required 00", m_axis_tvalid, busy);
        end
    endtask

    task automatic test_backpressure();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 32'h3F800000, 32'h3F800000, 0, 0, i, i == 39);
            tick();
            tests++;
            if (stall_req !== (i >= 33)) begin
                fails++;
                $display("FAIL stall_cycle_%0d: got %b required %b", i + 1, stall_req, i >= 33);
            end
        end
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        tick(); tick();
        tests++;
        if (stall_req !== 1'b1 || overflow !== 1'b0 || m_axis_tdata[159:128] !== 32'd0) begin
            fails++;
            $display("FAIL bp_hold: stall=%b ovf=%b head=%0d required 1 0 0", stall_req, overflow,
                     m_axis_tdata[159:128]);
        end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tests++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata[159:128] !== 32'(i) || m_axis_tlast !== (i == 39)) begin
                fails++;
                $display("FAIL bp_read_%0d: tvalid=%b tag=%0d last=%b required 1 %0d %b", i,
                         m_axis_tvalid, m_axis_tdata[159:128], m_axis_tlast, i, i == 39);
            end
            $display("[TB] bp read tag=%0d last=%b", m_axis_tdata[159:128], m_axis_tlast);
            tick();
        end
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || stall_req !== 1'b0) begin
            fails++;
            $display("FAIL bp_drained: tvalid=%b busy=%b stall=%b required 000", m_axis_tvalid, busy, stall_req);
        end
    endtask

    task automatic test_overrun_and_full();
        int rd_idx;
        logic [31:0] exp_tag;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 0, 0, 0, 0, i, 1'b0);
            tick();
        end
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        tick(); tick();
        tests++;
        if (overflow !== 1'b0 || m_axis_tvalid !== 1'b1 || m_axis_tdata[159:128] !== 32'd0) begin
            fails++;
            $display("FAIL full64: ovf=%b tvalid=%b head=%0d required 0 1 0", overflow, m_axis_tvalid,
                     m_axis_tdata[159:128]);
        end
        drive(1'b1, 0, 0, 0, 0, 64, 1'b0);
        tick();
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        tick(); tick();
        tests++;
        if (overflow !== 1'b1 || m_axis_tdata[159:128] !== 32'd0) begin
            fails++;
            $display("FAIL overrun65: ovf=%b head=%0d required 1 0", overflow, m_axis_tdata[159:128]);
        end
`ifdef FRAGMENT_RECEIVER_DROP_COUNT_EN
        tests++;
        if (drop_count !== 16'd1) begin
            fails++;
            $display("FAIL drop_count_1: got %0d required 1", drop_count);
        end
`endif
        // Full FIFO: first beat enters the conversion stage before reading
        // starts, so every following write meets a full FIFO with a read.
        rd_idx = 0;
        for (int c = 0; c < 200 && rd_idx < 85; c++) begin
            m_axis_tready = (c >= 1);
            if (c <= 20) begin
                drive(1'b1, 0, 0, 0, 0, 100 + c, 1'b0);
            end else begin
                drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                exp_tag = (rd_idx < 64) ? 32'(rd_idx) : 32'(100 + rd_idx - 64);
                tests++;
                if (m_axis_tdata[159:128] !== exp_tag) begin
                    fails++;
                    $display("FAIL full_rw_read_%0d: tag=%0d required %0d", rd_idx,
                             m_axis_tdata[159:128], exp_tag);
                end
                $display("[TB] full rw read tag=%0d", m_axis_tdata[159:128]);
                rd_idx++;
            end
            if (c >= 2 && c <= 21) begin
                tests++;
                if (stall_req !== 1'b1) begin
                    fails++;
                    $display("FAIL full_rw_stall_%0d: got %b required 1", c, stall_req);
                end
            end
            tick();
        end
        tests++;
        if (rd_idx != 85 || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full_rw_total: reads=%0d tvalid=%b busy=%b required 85 0 0", rd_idx,
                     m_axis_tvalid, busy);
        end
`ifdef FRAGMENT_RECEIVER_DROP_COUNT_EN
        tests++;
        if (drop_count !== 16'd1) begin
            fails++;
            $display("FAIL drop_count_after_rw: got %0d required 1", drop_count);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 0, 0, 0, 0, 200 + i, 1'b0);
            tick();
        end
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        tick(); tick();
        reset = 1'b1;
        drive(1'b1, 0, 0, 0, 0, 999, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b1, 32'h40000000, 32'hC0000000, 32'h3F800000, 7, 300, 1'b1);
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || stall_req !== 1'b0) begin
            fails++;
            $display("FAIL midreset_clear: tvalid=%b busy=%b ovf=%b stall=%b required 0000",
                     m_axis_tvalid, busy, overflow, stall_req);
        end
`ifdef FRAGMENT_RECEIVER_DROP_COUNT_EN
        tests++;
        if (drop_count !== 16'd0) begin
            fails++;
            $display("FAIL midreset_drop_count: got %0d required 0", drop_count);
        end
`endif
        tick();
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        tests++;
        if (m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL midreset_n1: tvalid=%b required 0", m_axis_tvalid);
        end
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b1 ||
            m_axis_tdata !== {32'd300, 32'd7, 32'h3F800000, 32'hFFFE0000, 32'h00020000}) begin
            fails++;
            $display("FAIL midreset_n2: tvalid=%b data=%h required 1 %h", m_axis_tvalid, m_axis_tdata,
                     {32'd300, 32'd7, 32'h3F800000, 32'hFFFE0000, 32'h00020000});
        end
        $display("[TB] post-reset beat tag=%0d", m_axis_tdata[159:128]);
        m_axis_tready = 1'b1;
        tick();
        tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset_drain: tvalid=%b busy=%b required 00", m_axis_tvalid, busy);
        end
    endtask

    initial begin
        reset         = 1'b1;
        m_axis_tready = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 1'b0);
        #1;
        test_reset();
        test_single_beat();
        test_convert();
        test_backpressure();
        test_overrun_and_full();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
